hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-cycle load/flush steering for a five-stage
// pipeline, a data-memory FSM for two-access indirect loads/stores, and stall/redirect counters.
module hazard_ctrl (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iMemAccess,
  input  logic        iMemIndirect,
  input  logic        iDmemResp,
  input  logic        iImemResp,
  input  logic        iBranchTaken,
  input  logic        iLoadUse,
  input  logic        iCountClr,
  output logic        oLoadPC,
  output logic        oPcSelTarget,
  output logic        oLoadIfId,
  output logic        oFlushIfId,
  output logic        oLoadIdEx,
  output logic        oFlushIdEx,
  output logic        oLoadExMem,
  output logic        oFlushExMem,
  output logic        oLoadMemWb,
  output logic        oFlushMemWb,
  output logic        oDmemReq,
  output logic        oDmemIndPhase,
  output logic        oLatchIndirect,
  output logic [15:0] oStallCount,
  output logic [15:0] oFlushCount
);

  typedef enum logic {M_IDLE = 1'b0, M_IND = 1'b1} mem_state_t;

  mem_state_t  state_r, state_next_s;
  logic        dstall_s;
  logic        redirect_s;
  logic [15:0] stall_count_r;
  logic [15:0] flush_count_r;

  // An indirect access always stalls its first phase, even when memory responds at once.
  assign dstall_s = iMemAccess & (~iDmemResp | ((state_r == M_IDLE) & iMemIndirect));

  // Data-memory FSM state register.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_r <= M_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state and prioritised pipeline steering.
  always_comb begin
    state_next_s   = state_r;
    oLatchIndirect = 1'b0;
    oLoadPC        = 1'b0;
    oPcSelTarget   = 1'b0;
    oLoadIfId      = 1'b0;
    oFlushIfId     = 1'b0;
    oLoadIdEx      = 1'b0;
    oFlushIdEx     = 1'b0;
    oLoadExMem     = 1'b0;
    oFlushExMem    = 1'b0;
    oLoadMemWb     = 1'b0;
    oFlushMemWb    = 1'b0;
    redirect_s     = 1'b0;

    case (state_r)
      M_IDLE: begin
        if (iMemAccess & iMemIndirect & iDmemResp) begin
          state_next_s   = M_IND;
          oLatchIndirect = ~iReset;
        end else begin
          state_next_s = M_IDLE;
        end
      end
      M_IND: begin
        if (iDmemResp) begin
          state_next_s = M_IDLE;
        end else begin
          state_next_s = M_IND;
        end
      end
      default: begin
        state_next_s = M_IDLE;
      end
    endcase

    if (iReset) begin
      redirect_s = 1'b0;
    end else if (dstall_s) begin
      oLoadMemWb  = 1'b1;
      oFlushMemWb = 1'b1;
    end else if (iBranchTaken & ~iImemResp) begin
      // Hold everything so an in-flight fetch is never abandoned.
      redirect_s = 1'b0;
    end else if (iBranchTaken) begin
      redirect_s   = 1'b1;
      oLoadPC      = 1'b1;
      oPcSelTarget = 1'b1;
      oLoadIfId    = 1'b1;
      oFlushIfId   = 1'b1;
      oLoadIdEx    = 1'b1;
      oFlushIdEx   = 1'b1;
      oLoadExMem   = 1'b1;
      oFlushExMem  = 1'b1;
      oLoadMemWb   = 1'b1;
    end else if (iLoadUse) begin
      oLoadIdEx  = 1'b1;
      oFlushIdEx = 1'b1;
      oLoadExMem = 1'b1;
      oLoadMemWb = 1'b1;
    end else if (~iImemResp) begin
      oLoadIfId  = 1'b1;
      oFlushIfId = 1'b1;
      oLoadIdEx  = 1'b1;
      oLoadExMem = 1'b1;
      oLoadMemWb = 1'b1;
    end else begin
      oLoadPC    = 1'b1;
      oLoadIfId  = 1'b1;
      oLoadIdEx  = 1'b1;
      oLoadExMem = 1'b1;
      oLoadMemWb = 1'b1;
    end
  end

  // Saturating performance counters; clear wins over a same-cycle increment.
  always_ff @(posedge iClk) begin
    if (iReset || iCountClr) begin
      stall_count_r <= 16'h0000;
      flush_count_r <= 16'h0000;
    end else begin
      if (~oLoadPC && (stall_count_r != 16'hFFFF)) begin
        stall_count_r <= stall_count_r + 16'h0001;
      end
      if (redirect_s && (flush_count_r != 16'hFFFF)) begin
        flush_count_r <= flush_count_r + 16'h0001;
      end
    end
  end

  assign oDmemReq      = iMemAccess & ~iReset;
  assign oDmemIndPhase = (state_r == M_IND);
  assign oStallCount   = stall_count_r;
  assign oFlushCount   = flush_count_r;

endmodule
